alu_seq: RTL and testbench

//   Execute-stage ALU that consumes the 4-bit alu_ctrl code from alu_control and operands from the

---
 rtl/alu_seq.sv | 157 +++++++++++++++
 tb/tb_alu_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq : execute-stage ALU with a start/busy/done handshake.
//
// Logic, arithmetic and compare ops finish in one edge. Shifts move one bit
// per edge in an internal accumulator.
//
// Handshake: a request is taken on a rising edge where start=1 and the FSM
// is IDLE. busy stays high while shift iterations remain after the accept
// edge. done is a one-cycle pulse that marks result/zero/illegal as freshly
// valid. start is ignored while busy.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   start    - request (accepted only when busy=0)
//   alu_ctrl - op code, sampled on accept
//   a, b     - operands; b[SHAMT_W-1:0] is the shift amount
//   busy     - shift iterations in progress
//   done     - one-cycle completion pulse
//   result   - registered result, held until the next completion
//   zero     - result == 0, updated with result
//   illegal  - last completed op had an unsupported code
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] cnt;
  logic [3:0]         sh_op;

  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  logic [WIDTH-1:0]   comb_res;
  logic               comb_illegal;
  logic [WIDTH-1:0]   first_step;
  logic [WIDTH-1:0]   next_step;

  // One 1-bit shift step; anything that is not SLL/SRL is treated as SRA,
  // which is safe because only shift codes ever reach this function's result.
  function automatic logic [WIDTH-1:0] shift_step(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    case (op)
      OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
      OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
      default: r = {v[WIDTH-1], v[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  always_comb begin
    shamt        = b[SHAMT_W-1:0];
    is_shift     = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
    first_step   = shift_step(alu_ctrl, a);
    next_step    = shift_step(sh_op, acc);
    comb_res     = '0;
    comb_illegal = 1'b0;
    case (alu_ctrl)
      OP_AND:  comb_res = a & b;
      OP_OR:   comb_res = a | b;
      OP_ADD:  comb_res = a + b;
      OP_SUB:  comb_res = a - b;
      OP_XOR:  comb_res = a ^ b;
      OP_SLT:  comb_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: comb_res = {{(WIDTH-1){1'b0}}, (a < b)};
      // Shift by zero completes immediately with the operand unchanged.
      OP_SLL, OP_SRL, OP_SRA: comb_res = a;
      default: comb_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      sh_op   <= OP_AND;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      zero    <= 1'b1;
      illegal <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_shift && (shamt != '0)) begin
              // The accept edge already performs the first of the s steps.
              if (shamt == SHAMT_W'(1)) begin
                result  <= first_step;
                zero    <= (first_step == '0);
                illegal <= 1'b0;
                done    <= 1'b1;
              end else begin
                acc   <= first_step;
                cnt   <= shamt - SHAMT_W'(1);
                sh_op <= alu_ctrl;
                busy  <= 1'b1;
                state <= SHIFT;
              end
            end else begin
              result  <= comb_res;
              zero    <= (comb_res == '0);
              illegal <= comb_illegal;
              done    <= 1'b1;
            end
          end
        end
        SHIFT: begin
          // cnt counts the steps still owed; the step with cnt==1 is the last.
          if (cnt == SHAMT_W'(1)) begin
            result  <= next_step;
            zero    <= (next_step == '0);
            illegal <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            acc <= next_step;
            cnt <= cnt - SHAMT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq : scoreboard bench for alu_seq. The driver issues requests and
// pushes the model's expected {illegal, zero, result} plus the edge number on
// which done must appear; an independent monitor pops on every done pulse.
// -----------------------------------------------------------------------------
module tb_alu_seq;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_ctrl(alu_ctrl),
    .a(a), .b(b), .busy(busy), .done(done),
    .result(result), .zero(zero), .illegal(illegal)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [WIDTH+1:0] exp_q[$];
  int               cyc_q[$];
  int               n_vec = 0;
  int               n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_shift_op(input logic [3:0] op);
    return (op == 4'd3) || (op == 4'd4) || (op == 4'd5);
  endfunction

  function automatic logic [WIDTH+1:0] ref_model(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    logic             ill;
    int               s;
    s   = int'(y[4:0]);
    r   = '0;
    ill = 1'b0;
    case (op)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd2: r = x + y;
      4'd6: r = x - y;
      4'd7: r = ($signed(x) < $signed(y)) ? 1 : 0;
      4'd8: r = x ^ y;
      4'd9: r = (x < y) ? 1 : 0;
      4'd3: r = x << s;
      4'd4: r = x >> s;
      4'd5: r = WIDTH'($signed(x) >>> s);
      default: ill = 1'b1;
    endcase
    return {ill, (r == '0), r};
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [WIDTH-1:0] y);
    if (is_shift_op(op) && (y[4:0] != 5'd0)) return int'(y[4:0]);
    return 1;
  endfunction

  // ---------------- driver ----------------
  // noise=1 pulses start with random ops while the DUT is busy.
  task automatic issue(input logic [3:0] op, input logic [WIDTH-1:0] x,
                       input logic [WIDTH-1:0] y, input bit noise);
    int lat;
    @(negedge clk);
    start    = 1'b1;
    alu_ctrl = op;
    a        = x;
    b        = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    lat   = ref_lat(op, y);
    exp_q.push_back(ref_model(op, x, y));
    cyc_q.push_back(cyc + lat - 1);
    if (lat == 1) check("busy_after_1cyc_accept", 64'(busy), 64'd0);
    for (int k = 0; k < lat - 1; k++) begin
      @(negedge clk);
      check("busy_during_shift", 64'(busy), 64'd1);
      if (noise) begin
        start    = 1'($urandom_range(0, 1));
        alu_ctrl = 4'($urandom_range(0, 15));
        a        = $urandom;
        b        = $urandom;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  // ---------------- monitor ----------------
  logic [WIDTH+1:0] mon_e;
  int               mon_c;

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL spurious_done: got done=1 expected no pending op (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = cyc_q.pop_front();
        check("result",      64'(result),  64'(mon_e[WIDTH-1:0]));
        check("zero",        64'(zero),    64'(mon_e[WIDTH]));
        check("illegal",     64'(illegal), 64'(mon_e[WIDTH+1]));
        check("done_edge",   64'(cyc),     64'(mon_c));
        check("busy_at_done", 64'(busy),   64'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [3:0] legal_ops[10] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd3, 4'd4, 4'd5};

  function automatic logic [WIDTH-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    alu_ctrl = '0;
    a        = '0;
    b        = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",    64'(busy),    64'd0);
    check("rst_done",    64'(done),    64'd0);
    check("rst_result",  64'(result),  64'd0);
    check("rst_zero",    64'(zero),    64'd1);
    check("rst_illegal", 64'(illegal), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed cases.
    issue(4'd2, 32'd7, 32'd5, 1'b0);                  // ADD -> 12
    issue(4'd6, 32'd5, 32'd5, 1'b0);                  // SUB -> 0, zero
    issue(4'd6, 32'd0, 32'd1, 1'b0);                  // SUB -> FFFFFFFF
    issue(4'd7, 32'hFFFF_FFFF, 32'd1, 1'b0);          // SLT -> 1
    issue(4'd9, 32'hFFFF_FFFF, 32'd1, 1'b0);          // SLTU -> 0
    issue(4'd5, 32'h8000_0000, 32'd4, 1'b1);          // SRA -> F8000000, start noise
    issue(4'd3, 32'd1, 32'd0, 1'b0);                  // SLL by 0
    issue(4'd3, 32'd1, 32'd1, 1'b0);                  // SLL by 1, latency 1
    issue(4'hF, 32'd9, 32'd9, 1'b0);                  // illegal
    issue(4'd0, 32'hF0F0, 32'hFF00, 1'b0);            // AND clears illegal
    issue(4'd4, 32'hFFFF_FFFF, 32'd31, 1'b1);         // SRL max shift
    issue(4'd8, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0);  // XOR all ones

    // Randomized traffic, including back-to-back single-cycle ops.
    for (int i = 0; i < 200; i++) begin
      logic [3:0] op;
      if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(10, 15));
      else                           op = legal_ops[$urandom_range(0, 9)];
      repeat ($urandom_range(0, 2)) @(posedge clk);
      issue(op, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a long shift: abort with no done pulse.
    issue(4'd2, 32'd7, 32'd5, 1'b0);
    @(negedge clk);
    start    = 1'b1;
    alu_ctrl = 4'd3;
    a        = 32'd1;
    b        = 32'd31;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("busy_before_abort", 64'(busy), 64'd1);
    end
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy",    64'(busy),    64'd0);
    check("abort_done",    64'(done),    64'd0);
    check("abort_result",  64'(result),  64'd0);
    check("abort_zero",    64'(zero),    64'd1);
    check("abort_illegal", 64'(illegal), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("idle_after_abort", 64'(busy), 64'd0);

    // One more op to show the FSM came back cleanly.
    issue(4'd1, 32'h1200, 32'h0034, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 100 && exp_q.size() != 0; w++) @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
